// File: rtl/scale_mux.sv
// Parameterised 2:1 word select with a zero-latency result and an
// enable-gated registered copy whose valid flag is sticky until reset.
module scale_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             sel_a,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_valid
);

    logic [WIDTH-1:0] mux_s;
    logic [WIDTH-1:0] out_q_r;
    logic             valid_r;

    // An X/Z select merges agreeing bits through the conditional operator.
    assign mux_s = sel_a ? in_a : in_b;
    assign out   = mux_s;

    // Capture stage: load on en, hold otherwise; valid stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_r <= '0;
            valid_r <= 1'b0;
        end else if (en) begin
            out_q_r <= mux_s;
            valid_r <= 1'b1;
        end else begin
            out_q_r <= out_q_r;
            valid_r <= valid_r;
        end
    end

    assign out_q     = out_q_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_scale_mux.sv
// Directed self-checking bench for scale_mux at WIDTH=8 and WIDTH=1.
module tb_scale_mux;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       sel_a;
    logic       en;
    logic [7:0] out;
    logic [7:0] out_q;
    logic       out_valid;

    logic       in_a1;
    logic       in_b1;
    logic       sel_a1;
    logic       en1;
    logic       out1;
    logic       out_q1;
    logic       out_valid1;

    int n_cmp;
    int n_bad;

    scale_mux #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_a(in_a), .in_b(in_b), .sel_a(sel_a),
        .en(en), .out(out), .out_q(out_q), .out_valid(out_valid)
    );

    scale_mux #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_a(in_a1), .in_b(in_b1), .sel_a(sel_a1),
        .en(en1), .out(out1), .out_q(out_q1), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        in_a  = 8'h00;
        in_b  = 8'hFF;
        sel_a = 1'b0;
        en1   = 1'b1;
        in_a1 = 1'b0;
        in_b1 = 1'b0;
        sel_a1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_out_q: got %h want 00", out_q);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_out_comb: got %h want FF", out);
        end
        n_cmp++;
        if (out_valid1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_w1_valid: got %b want 0", out_valid1);
        end
        @(negedge clk);
        en    = 1'b0;
        en1   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_q !== 8'h00) begin
            n_bad++;
            $display("FAIL release_no_en: got q=%h v=%b want q=00 v=0", out_q, out_valid);
        end
    endtask

    task automatic test_comb_sweep();
        logic [7:0] va  [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] vb  [6] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic       vs  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp [6] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF};
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_a  = va[i];
            in_b  = vb[i];
            sel_a = vs[i];
            #1;
            n_cmp++;
            if (out !== exp[i]) begin
                n_bad++;
                $display("FAIL comb_sweep[%0d]: got %h want %h", i, out, exp[i]);
            end
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        in_a  = 8'hA5;
        in_b  = 8'h5A;
        sel_a = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 8'hA5 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL capture_a: got q=%h v=%b want q=A5 v=1", out_q, out_valid);
        end
        sel_a = 1'b0;
        #1;
        n_cmp++;
        if (out_q !== 8'hA5) begin
            n_bad++;
            $display("FAIL capture_between_edges: got %h want A5", out_q);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 8'h5A || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL capture_b: got q=%h v=%b want q=5A v=1", out_q, out_valid);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        in_a  = 8'hA5;
        sel_a = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        en    = 1'b0;
        in_a  = 8'h3C;
        #1;
        n_cmp++;
        if (out !== 8'h3C) begin
            n_bad++;
            $display("FAIL hold_comb: got %h want 3C", out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_q !== 8'hA5 || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_cycle[%0d]: got q=%h v=%b want q=A5 v=1", i, out_q, out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_b  = 8'h5A;
        sel_a = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 8'h5A || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset: got q=%h v=%b want q=5A v=1", out_q, out_valid);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_q !== 8'h00 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear: got q=%h v=%b want q=00 v=0", out_q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_b  = 8'hC3;
        sel_a = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_q !== 8'hC3 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_capture: got q=%h v=%b want q=C3 v=1", out_q, out_valid);
        end
    endtask

    task automatic test_width1();
        logic seq [3] = '{1'b0, 1'b1, 1'b0};
        @(negedge clk);
        in_a1 = 1'b1;
        in_b1 = 1'b0;
        en1   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sel_a1 = seq[i];
            #1;
            n_cmp++;
            if (out1 !== seq[i]) begin
                n_bad++;
                $display("FAIL w1_comb[%0d]: got %b want %b", i, out1, seq[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (out_q1 !== seq[i] || out_valid1 !== 1'b1) begin
                n_bad++;
                $display("FAIL w1_reg[%0d]: got q=%b v=%b want q=%b v=1", i, out_q1, out_valid1, seq[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_comb_sweep();
        test_capture();
        test_hold();
        test_async_reset();
        test_width1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
